// File: rtl/vector_pkg.sv
// Shared widths, state encoding and byte-offset constant for the vector
// store serializer.
package vector_pkg;

    localparam int VW_DEFAULT     = 128;
    localparam int DW_DEFAULT     = 32;
    localparam int LANES          = VW_DEFAULT / DW_DEFAULT;
    localparam int BYTES_PER_WORD = DW_DEFAULT / 8;

    typedef enum logic {
        IDLE   = 1'b0,
        VSTORE = 1'b1
    } state_t;

endpackage

// File: rtl/vector_ld_st.sv
// Memory-stage store unit: scalar stores pass through in one cycle, vector
// stores are captured and written one DW-bit lane per cycle while the CPU stalls.
module vector_ld_st
    import vector_pkg::*;
#(
    parameter int VW = VW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_wen,
    input  logic          mem_wen_v,
    input  logic [VW-1:0] input_vector_B,
    output logic          stall_cpu,
    output logic [DW-1:0] m_address,
    output logic [DW-1:0] m_wdata,
    output logic          m_we,
    output state_t        state_dbg
);

    localparam int NLANES = VW / DW;
    localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int BPW    = DW / 8;

    // Handshake: requests are single-cycle strobes sampled at a rising edge
    // while IDLE; no ready is returned, stall_cpu holds the CPU until the
    // serializer is back in IDLE, and requests seen in VSTORE are dropped.

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [VW-1:0]       shadow_q, shadow_d;
    logic                stall_d, we_d;
    logic [DW-1:0]       addr_d, wdata_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            shadow_q  <= '0;
            stall_cpu <= 1'b0;
            m_we      <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            shadow_q  <= shadow_d;
            stall_cpu <= stall_d;
            m_we      <= we_d;
            m_address <= addr_d;
            m_wdata   <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        shadow_d = shadow_q;
        stall_d  = stall_cpu;
        we_d     = 1'b0;
        addr_d   = m_address;
        wdata_d  = m_wdata;
        case (state_q)
            IDLE: begin
                // Vector request wins; a simultaneous scalar request is dropped.
                if (mem_wen_v) begin
                    shadow_d = input_vector_B;
                    lane_d   = '0;
                    state_d  = VSTORE;
                    stall_d  = 1'b1;
                end else if (mem_wen) begin
                    we_d    = 1'b1;
                    wdata_d = input_vector_B[DW-1:0];
                    addr_d  = '0;
                end
            end
            VSTORE: begin
                we_d    = 1'b1;
                wdata_d = shadow_q[int'(lane_q)*DW +: DW];
                addr_d  = DW'(lane_q) * DW'(BPW);
                if (lane_q == LANE_W'(NLANES - 1)) begin
                    state_d = IDLE;
                    stall_d = 1'b0;
                    lane_d  = '0;
                end else begin
                    lane_d = lane_q + LANE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_vector_ld_st.sv
// Directed bench for vector_ld_st: reset, scalar pass-through, vector
// serialization, request priority, in-flight disturbance and mid-transfer reset.
module tb_vector_ld_st;
    import vector_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         mem_wen = 1'b0;
    logic         mem_wen_v = 1'b0;
    logic [127:0] input_vector_B = '0;
    logic         stall_cpu;
    logic [31:0]  m_address;
    logic [31:0]  m_wdata;
    logic         m_we;
    state_t       state_dbg;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    vector_ld_st dut (
        .clk            (clk),
        .rst            (rst),
        .mem_wen        (mem_wen),
        .mem_wen_v      (mem_wen_v),
        .input_vector_B (input_vector_B),
        .stall_cpu      (stall_cpu),
        .m_address      (m_address),
        .m_wdata        (m_wdata),
        .m_we           (m_we),
        .state_dbg      (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic stall);
        chk({tag, " m_we"},      32'(m_we),      32'(we));
        chk({tag, " m_address"}, m_address,      addr);
        chk({tag, " m_wdata"},   m_wdata,        data);
        chk({tag, " stall_cpu"}, 32'(stall_cpu), 32'(stall));
    endtask

    // Called one negedge after the request edge T; checks edges T+1..T+5.
    // With disturb set, B and both requests are toggled during VSTORE.
    task automatic expect_vector(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] w2, input logic [31:0] w3, input bit disturb);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        chk_out({tag, " accept"}, 1'b0, m_address, m_wdata, 1'b1);
        chk({tag, " state"}, 32'(state_dbg), 32'(VSTORE));
        for (int k = 0; k < 4; k++) begin
            if (disturb) begin
                input_vector_B = ~input_vector_B;
                mem_wen        = 1'b1;
                mem_wen_v      = 1'b1;
            end
            @(negedge clk);
            chk_out($sformatf("%s lane%0d", tag, k), 1'b1, 32'(k * 4), w[k], (k < 3));
        end
        mem_wen   = 1'b0;
        mem_wen_v = 1'b0;
        @(negedge clk);
        chk_out({tag, " tail"}, 1'b0, 32'd12, w[3], 1'b0);
        chk({tag, " tail state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    initial begin
        // Reset held for two cycles, then released with no requests.
        input_vector_B = 128'h00000000_00012121_444511AA_AFFFFFFF;
        mem_wen_v      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b0);
        mem_wen_v = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk_out("post_reset", 1'b0, 32'h0, 32'h0, 1'b0);

        // Scalar store: one-cycle latency, no stall.
        mem_wen = 1'b1;
        @(negedge clk);
        mem_wen = 1'b0;
        chk_out("scalar", 1'b1, 32'h0, 32'hAFFFFFFF, 1'b0);
        @(negedge clk);
        chk_out("scalar_idle", 1'b0, 32'h0, 32'hAFFFFFFF, 1'b0);

        // Vector store.
        mem_wen_v = 1'b1;
        @(negedge clk);
        mem_wen_v = 1'b0;
        expect_vector("vec", 32'hAFFFFFFF, 32'h444511AA, 32'h00012121, 32'h00000000, 1'b0);

        // Both requests together: vector wins, no scalar write.
        mem_wen   = 1'b1;
        mem_wen_v = 1'b1;
        @(negedge clk);
        mem_wen   = 1'b0;
        mem_wen_v = 1'b0;
        expect_vector("both", 32'hAFFFFFFF, 32'h444511AA, 32'h00012121, 32'h00000000, 1'b0);

        // Disturb B and requests while serializing.
        input_vector_B = 128'h11111111_22222222_33333333_44444444;
        mem_wen_v      = 1'b1;
        @(negedge clk);
        mem_wen_v = 1'b0;
        expect_vector("disturb", 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 1'b1);

        // Reset after lane 1 aborts immediately; the next request restarts at lane 0.
        input_vector_B = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
        mem_wen_v      = 1'b1;
        @(negedge clk);
        mem_wen_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_out("abort_lane1", 1'b1, 32'd4, 32'hBBBB0001, 1'b1);
        rst = 1'b0;
        #1;
        chk_out("abort_async", 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk_out("abort_hold", 1'b0, 32'h0, 32'h0, 1'b0);
        rst            = 1'b1;
        input_vector_B = 128'h87654321_0FEDCBA9_12345678_9ABCDEF0;
        mem_wen_v      = 1'b1;
        @(negedge clk);
        mem_wen_v = 1'b0;
        expect_vector("restart", 32'h9ABCDEF0, 32'h12345678, 32'h0FEDCBA9, 32'h87654321, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
